// File: rtl/arm_mc_pkg.sv
// Shared types and constants for the multicycle conditional-execution logic.
package arm_mc_pkg;

  // ARM condition field encodings (Instr[31:28]).
  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  // Instruction-phase state of the conditional logic.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2
  } clstate_t;

  // Bit positions of the flags inside {N,Z,C,V}.
  localparam int N = 3;
  localparam int Z = 2;
  localparam int C = 1;
  localparam int V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluator: decides whether an instruction
// with condition field Cond executes under the current {N,Z,C,V} flags.
module cond_check
  import arm_mc_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic neg, zero, carry, ovf, ge;

  assign neg   = Flags[N];
  assign zero  = Flags[Z];
  assign carry = Flags[C];
  assign ovf   = Flags[V];
  assign ge    = (neg == ovf);

  // Condition table lookup; the reserved 1111 code behaves like AL.
  always_comb begin
    CondEx = 1'b1;
    case (cond_t'(Cond))
      EQ:      CondEx = zero;
      NE:      CondEx = ~zero;
      CS:      CondEx = carry;
      CC:      CondEx = ~carry;
      MI:      CondEx = neg;
      PL:      CondEx = ~neg;
      VS:      CondEx = ovf;
      VC:      CondEx = ~ovf;
      HI:      CondEx = carry & ~zero;
      LS:      CondEx = ~carry | zero;
      GE:      CondEx = ge;
      LT:      CondEx = ~ge;
      GT:      CondEx = ~zero & ge;
      LE:      CondEx = zero | ~ge;
      AL:      CondEx = 1'b1;
      default: CondEx = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_logic_mc.sv
// Multicycle conditional logic: tracks the instruction phase, latches the
// condition result at the end of DECODE, gates the decoder's write requests
// during EXEC, owns the architectural flags and counts decoded/squashed
// instructions.
//
// state  | meaning
// IDLE   | after reset, no instruction in flight; all writes masked
// DECODE | condition evaluated against current flags, writes masked
// EXEC   | writes enabled when the latched condition passed
module cond_logic_mc
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        NextPC,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic [3:0]  Flags,
  output logic        CondExR,
  output logic [15:0] InstrCnt,
  output logic [15:0] SquashCnt
);

  clstate_t state;
  logic     CondEx;
  logic     exec_ok;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (Flags),
    .CondEx (CondEx)
  );

  // Execution is allowed only in EXEC with a passing latched condition;
  // state resets asynchronously, so reset kills these gates at once.
  assign exec_ok  = (state == EXEC) & CondExR;
  assign PCWrite  = NextPC | (PCS & exec_ok);
  assign RegWrite = RegW & exec_ok;
  assign MemWrite = MemW & exec_ok;

  // Phase FSM plus the condition latch and counters updated on DECODE edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      CondExR   <= 1'b0;
      InstrCnt  <= 16'd0;
      SquashCnt <= 16'd0;
    end else begin
      case (state)
        IDLE:    state <= NextPC ? DECODE : IDLE;
        DECODE:  state <= NextPC ? DECODE : EXEC;
        EXEC:    state <= NextPC ? DECODE : EXEC;
        default: state <= IDLE;
      endcase
      if (state == DECODE) begin
        CondExR  <= CondEx;
        InstrCnt <= InstrCnt + 16'd1;
        if (!CondEx) begin
          SquashCnt <= SquashCnt + 16'd1;
        end
      end
    end
  end

  // Flag register: N,Z and C,V halves update independently when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Flags <= 4'b0000;
    end else begin
      if (FlagW[1] && exec_ok) begin
        Flags[N:Z] <= ALUFlags[N:Z];
      end
      if (FlagW[0] && exec_ok) begin
        Flags[C:V] <= ALUFlags[C:V];
      end
    end
  end

endmodule

// File: doc/cond_logic_mc.md
COND_LOGIC_MC -- requirements
Module: cond_logic_mc

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high.
REQ-003 Cond  in  4  instruction condition field, Instr[31:28].
REQ-004 ALUFlags  in  4  ALU result flags {N,Z,C,V}.
REQ-005 FlagW  in  2  from decoder; [1] requests an N,Z write, [0] requests a C,V write.
REQ-006 PCS, RegW, MemW  in  1 each  ungated write requests from the decoder.
REQ-007 NextPC  in  1  fetch-cycle PC update request; never gated.
REQ-008 PCWrite, RegWrite, MemWrite  out  1 each  gated write enables.
REQ-009 Flags  out  4  architectural {N,Z,C,V} register.
REQ-010 CondExR  out  1  registered condition-pass for the current instruction.
REQ-011 InstrCnt, SquashCnt  out  16 each  decoded-instruction count and failed-condition count.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, DECODE and EXEC.
REQ-013 In any state, NextPC=1 -> DECODE next cycle.
REQ-014 From DECODE with NextPC=0 -> EXEC; EXEC and IDLE SHALL hold while NextPC=0.
REQ-015 Condition-pass CondEx SHALL be computed combinationally from Cond and Flags.
- 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C
- 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V
- 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V
- 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
REQ-016 CondExR SHALL load CondEx only at the edge ending a DECODE cycle and SHALL hold otherwise; it is 0 in IDLE.
REQ-017 PCWrite SHALL equal NextPC | (PCS & CondExR & state==EXEC).
REQ-018 RegWrite SHALL equal RegW & CondExR & (state==EXEC).
REQ-019 MemWrite SHALL equal MemW & CondExR & (state==EXEC).
REQ-020 In DECODE and IDLE, PCS, RegW and MemW SHALL be masked to 0.
REQ-021 When FlagW[1] & CondExR & EXEC, Flags[3:2] SHALL load ALUFlags[3:2] at the clock edge.
REQ-022 When FlagW[0] & CondExR & EXEC, Flags[1:0] SHALL load ALUFlags[1:0] at the clock edge.
REQ-023 The two flag halves SHALL update independently; otherwise they hold.
REQ-024 A flag update and a condition evaluation in the same cycle SHALL use the pre-update Flags value, because the register updates at the edge.
REQ-025 NextPC coinciding with PCS in EXEC SHALL give PCWrite=1 and a single transition to DECODE.
REQ-026 InstrCnt SHALL increment by 1 at each DECODE-cycle edge.
REQ-027 SquashCnt SHALL increment by 1 at each DECODE-cycle edge where CondEx=0.
REQ-028 Both counters SHALL wrap from 0xFFFF to 0x0000 with no saturation and no flag.
REQ-029 All outputs other than PCWrite, RegWrite and MemWrite SHALL be registered; there is no added latency beyond the edges stated above.

Reset
REQ-030 On reset the block SHALL set state=IDLE, Flags=0000, CondExR=0, InstrCnt=0 and SquashCnt=0.
REQ-031 Reset asserted mid-instruction SHALL abort immediately: RegWrite and MemWrite go to 0 combinationally, and PCWrite follows NextPC only.
REQ-032 After reset deassertion, the first NextPC SHALL start the normal DECODE sequence.

Structure
REQ-033 Package arm_mc_pkg SHALL hold the cond_t enum (16 ARM codes), the clstate_t enum {IDLE,DECODE,EXEC} and the flag index constants N=3, Z=2, C=1, V=0.
REQ-034 The condition table SHALL be a combinational sub-module cond_check (inputs Cond, Flags; output CondEx), instantiated once.
REQ-035 The block SHALL contain no latches, and every case statement SHALL have a default.

Verification
REQ-036 Reset, then NextPC pulse, Cond=1110, RegW=1 in EXEC -> RegWrite=1; InstrCnt=1; SquashCnt=0.
REQ-037 Flags=0100, Cond=0000 (EQ), MemW=1 in EXEC -> MemWrite=1; same stimulus with Flags=0000 -> MemWrite=0 and SquashCnt increments.
REQ-038 Cond=1110, ALUFlags=1011, FlagW=10 in EXEC -> Flags=10xx with C,V unchanged; then FlagW=01 -> Flags[1:0]=11.
REQ-039 Cond=1011 (LT), Flags N=1, V=0, PCS=1 in EXEC -> PCWrite=1; with NextPC=1 and PCS=0 in the same cycle -> PCWrite=1 regardless of CondExR.
REQ-040 Preload InstrCnt=0xFFFF via 65535 NextPC pulses, then one more pulse -> InstrCnt=0x0000.
REQ-041 Assert reset during EXEC with RegW=1 -> RegWrite=0 immediately, Flags=0000, state=IDLE, counters=0.
